// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame states, protocol prefix bytes, game key make codes
// and the frame parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_S = 8'h1B;

  // A PS/2 frame is odd parity over the data bits and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data lines into the clk domain and flags each
// falling edge of the keyboard clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; the lines idle high, so resetting to 1
  // avoids a false edge at reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk};
      data_ff  <= {data_ff[0], ps2_data};
      clk_prev <= clk_ff[1];
    end
  end

  assign data_s = data_ff[1];
  assign fall   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: frames 11-bit packets into bytes, flags bad frames and
// timeouts, and tracks the make code of the currently held key.
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       byte_valid,
  output logic       frame_error,
  output logic [7:0] keycode
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  frame_state_e   state, state_n;
  logic           data_s, fall;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [TW-1:0]  timer;
  logic           break_pending;
  logic           frame_ok, frame_bad, timed_out;

  ps2_sync_edge u_sync_edge (
    .clk     (clk),
    .resetn  (resetn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data_s  (data_s),
    .fall    (fall)
  );

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_n   = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timed_out = 1'b0;
    if (state != IDLE && !fall && timer == TMAX) begin
      state_n   = IDLE;
      timed_out = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_s) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (data_s && odd_parity_ok(shreg, par_bit)) frame_ok = 1'b1;
          else                                          frame_bad = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
      timer   <= '0;
    end else begin
      if (state != DATA)             bit_cnt <= 3'd0;
      else if (fall)                 bit_cnt <= bit_cnt + 3'd1;

      if (timed_out || (fall && state == IDLE)) shreg <= 8'h00;
      else if (fall && state == DATA)           shreg <= {data_s, shreg[7:1]};

      if (fall && state == PARITY) par_bit <= data_s;

      // Saturating: the timeout fires on reaching TMAX, never wraps past it.
      if (fall || timed_out || state == IDLE) timer <= '0;
      else if (timer != TMAX)                 timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scancode      <= 8'h00;
      byte_valid    <= 1'b0;
      frame_error   <= 1'b0;
      keycode       <= 8'h00;
      break_pending <= 1'b0;
    end else begin
      byte_valid  <= frame_ok;
      frame_error <= frame_bad | timed_out;
      if (frame_ok) begin
        scancode <= shreg;
        if (shreg == PS2_BREAK) begin
          break_pending <= 1'b1;
        end else if (shreg != PS2_EXT) begin
          if (break_pending) begin
            if (shreg == keycode) keycode <= 8'h00;
            break_pending <= 1'b0;
          end else begin
            keycode <= shreg;
          end
        end
      end
    end
  end

endmodule
